// File: rtl/sfifo_rd_stream.sv
// sfifo_rd_stream: read-side adapter for the synchronous FIFO.
// Pops the FIFO on credit (pend < BUF_D), absorbs the FIFO's FIFO_DLY-cycle
// read latency, and presents returned words as a valid/ready stream through
// a small circular skid buffer. Forwards flush and tracks underflow.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   fifo_re             pop request to the FIFO
//   fifo_rd             FIFO read data (valid FIFO_DLY cycles after a pop)
//   fifo_empt           FIFO empty
//   fifo_udf            FIFO underflow pulse
//   fifo_fsh            flush to the FIFO (combinational copy of flush)
//   flush               flush request from control
//   m_valid/m_data      output stream beat
//   m_ready             downstream accept
//   pend                words in flight plus words buffered
//   udf_err             sticky underflow flag, cleared by rst or flush
module sfifo_rd_stream #(
  parameter int unsigned FIFO_W   = 32,
  parameter int unsigned FIFO_DLY = 0,
  parameter int unsigned BUF_D    = FIFO_DLY + 2,
  parameter int unsigned CNT_W    = $clog2(BUF_D + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_re,
  input  logic [FIFO_W-1:0] fifo_rd,
  input  logic              fifo_empt,
  input  logic              fifo_udf,
  output logic              fifo_fsh,
  input  logic              flush,
  output logic              m_valid,
  output logic [FIFO_W-1:0] m_data,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  pend,
  output logic              udf_err
);

  localparam int unsigned      PTR_W    = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_D - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUF_D);

  logic [FIFO_W-1:0] mem_q [BUF_D];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic [FIFO_W-1:0] m_data_q, m_data_d;
  logic              udf_q, udf_d;
  logic              ret;     // a popped word is on fifo_rd this cycle
  logic              we;
  logic              accept;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Credit comes only from the registered pend; a same-cycle accept does not help.
  assign fifo_re  = !rst && !flush && !fifo_empt && (pend_q < CNT_MAX);
  assign fifo_fsh = flush;
  assign m_valid  = (cnt_q != '0);
  assign m_data   = m_data_q;
  assign pend     = pend_q;
  assign udf_err  = udf_q;
  assign accept   = m_valid && m_ready;

  // In-flight tracker: one valid bit per outstanding pop, aligned to the FIFO delay.
  if (FIFO_DLY == 0) begin : g_no_dly
    assign ret = fifo_re;
  end else begin : g_dly
    logic [FIFO_DLY-1:0] sh_q;
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        sh_q <= '0;
      end else begin
        sh_q <= (sh_q << 1) | FIFO_DLY'(fifo_re);
      end
    end
    assign ret = sh_q[FIFO_DLY-1];
  end

  always_comb begin
    we       = ret;
    rd_ptr_d = accept ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = we ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    cnt_d    = cnt_q + CNT_W'(we) - CNT_W'(accept);
    pend_d   = pend_q + CNT_W'(fifo_re) - CNT_W'(accept);
    // Next head: bypass the incoming word when it lands in the head slot.
    m_data_d = (we && (wr_ptr_q == rd_ptr_d)) ? fifo_rd : mem_q[rd_ptr_d];
    udf_d    = udf_q | fifo_udf;
    if (flush) begin
      we       = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      pend_d   = '0;
      m_data_d = '0;
      udf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      m_data_q <= '0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      m_data_q <= m_data_d;
      udf_q    <= udf_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem_q[wr_ptr_q] <= fifo_rd;
    end
  end

endmodule

// File: doc/sfifo_rd_stream.md
# sfifo_rd_stream

Read-side adapter placed directly downstream of the synchronous FIFO. It issues pops on the FIFO read port and absorbs the FIFO's fixed output delay, then presents the popped words as a valid/ready stream with full throughput and no data loss under backpressure. It also forwards flush to the FIFO and reports pop-side errors.

## Interface
Parameters:
- FIFO_W, 32, data width; must match the FIFO.
- FIFO_DLY, 0, FIFO output delay: data for a pop in cycle t is on fifo_rd in cycle t+FIFO_DLY (0 = show-ahead, same cycle).
- BUF_D, FIFO_DLY+2, skid buffer depth (derived; do not override).
- CNT_W, $clog2(BUF_D+1), width of pend (derived).

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- fifo_re  out  1  pop request to FIFO
- fifo_rd  in  FIFO_W  FIFO read data
- fifo_empt  in  1  FIFO empty
- fifo_udf  in  1  FIFO underflow pulse
- fifo_fsh  out  1  flush to FIFO; equals flush combinationally
- flush  in  1  flush request from control
- m_valid  out  1  output beat valid
- m_data  out  FIFO_W  output beat data
- m_ready  in  1  downstream accept
- pend  out  CNT_W  words in flight plus words buffered (registered)
- udf_err  out  1  sticky underflow flag

## Operation
- Reset (rst=1 at an edge): m_valid=0, m_data=0, pend=0, udf_err=0, in-flight tracker cleared, buffer empty. fifo_re=0 while rst=1.
- Pop issue: fifo_re = !rst && !flush && !fifo_empt && (pend < BUF_D). Only the registered pend is used; a same-cycle m_ready does not grant extra credit.
- In-flight tracking: shift register of FIFO_DLY valid bits; bit 0 loads fifo_re each cycle. If the bit leaving the last stage is 1, fifo_rd is written into the buffer that cycle. With FIFO_DLY=0, fifo_rd is written in the pop cycle itself.
- Buffer: BUF_D-entry circular FIFO with read/write pointers that wrap at BUF_D (BUF_D is not required to be a power of 2). m_valid = buffer non-empty. m_data = head entry, registered. Head advances on m_valid && m_ready.
- pend next = pend + fifo_re − (m_valid && m_ready). It never exceeds BUF_D, so a returning word always has a free slot. Overflow is impossible by construction; the bench asserts it.
- Backpressure: while m_valid && !m_ready, m_data and m_valid hold stable.
- Flush (flush=1 at an edge):
  - The buffer empties and all in-flight bits clear; words returning later from earlier pops are discarded.
  - pend becomes 0 and udf_err clears.
  - A beat with m_valid && m_ready in the flush cycle counts as transferred.
  - No pop is issued in the flush cycle.
- udf_err: set on fifo_udf=1. Held until rst or flush. Set has priority over clear only when rst=0 and flush=0.

## Timing
- Pop-to-output latency: a pop at cycle t gives m_valid=1 at t+FIFO_DLY+1 when the buffer was empty.
- Throughput: one word per cycle sustained while FIFO non-empty and m_ready=1. Steady state: pend=FIFO_DLY+1 < BUF_D.
- Stall: with m_ready=0, pops continue until pend=BUF_D, then fifo_re=0 until a beat is accepted.
- Resume: first pop occurs the cycle after an accept that drops pend below BUF_D.
- Simultaneous events:
  - Write and read of the buffer in the same cycle: both take effect.
  - Accept of the last buffered word in the same cycle a return arrives: m_valid stays 1 with the new word.
- Reset mid-stream: identical to the reset state above. Words returning from pops before reset are discarded.

## Test plan
- FIFO_DLY=2, FIFO preloaded with 0x10..0x17, m_ready=1 -> fifo_re high 8 cycles back-to-back. m_valid first at cycle 3 after the first pop. m_data 0x10..0x17 on consecutive cycles. pend peaks at 3.
- FIFO_DLY=2, 8 words, m_ready=0 -> exactly 4 pops, then fifo_re=0 and pend=4. Raise m_ready -> 0x10..0x17 in order, no gaps after the first.
- FIFO_DLY=0, random m_ready (50%) over 1000 words -> in-order, lossless output. Stable m_data under stall. pend never >2.
- FIFO_DLY=2, pops in flight and 2 words buffered, pulse flush -> fifo_fsh=1 same cycle. Next cycle m_valid=0 and pend=0. Late returns never appear on m_data.
- fifo_udf pulse -> udf_err=1 from the next cycle and held. flush -> udf_err=0.
- rst asserted with 3 words buffered -> next cycle m_valid=0, m_data=0, pend=0, fifo_re=0.
